// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, major opcodes, field slices
// and the opcode classifier used by the operand-fetch stage.
package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        logic illegal;
    } op_class_t;

    function automatic reg_idx_t rd_of(input xword_t instr);
        return instr[RD_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t rs1_of(input xword_t instr);
        return instr[RS1_LSB +: REG_IDX_W];
    endfunction

    function automatic reg_idx_t rs2_of(input xword_t instr);
        return instr[RS2_LSB +: REG_IDX_W];
    endfunction

    function automatic op_class_t classify(input logic [6:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL: c.use_rd = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                c.use_rs1 = 1'b1;
                c.use_rd  = 1'b1;
            end
            OPC_OP: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
                c.use_rd  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                c.use_rs1 = 1'b1;
                c.use_rs2 = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits; set wins over clear on the same index.
// Ports: set_en/set_addr, clr_en/clr_addr, qa/qb pending queries, busy.
module scoreboard
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_IDX_W-1:0] set_addr,
    input  logic                clr_en,
    input  logic [REG_IDX_W-1:0] clr_addr,
    input  logic [REG_IDX_W-1:0] qa_addr,
    output logic                qa_pend,
    input  logic [REG_IDX_W-1:0] qb_addr,
    output logic                qb_pend,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // A query is pending only if the bit is not retiring this cycle.
    assign qa_pend = busy_q[qa_addr] && !(clr_en && clr_addr == qa_addr);
    assign qb_pend = busy_q[qb_addr] && !(clr_en && clr_addr == qb_addr);
    assign busy    = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// RV32I decode/operand-fetch stage: rf read, wb bypass, busy scoreboard.
// Ports: in_* from fetch, rf_rd_* to regfile, wb_* snoop, out_* to execute.
module operand_fetch
    import rv32i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic [REG_IDX_W-1:0] rf_rd_addr0,
    output logic [REG_IDX_W-1:0] rf_rd_addr1,
    input  logic [XLEN-1:0]      rf_rd_data0,
    input  logic [XLEN-1:0]      rf_rd_data1,
    input  logic                 wb_ena,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_instr,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_illegal
);

    op_class_t   cls;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    rd;
    logic        pend1;
    logic        pend2;
    logic        pend_rd;
    logic        hazard;
    logic        capture;
    logic        out_fire;
    logic [NUM_REGS-1:0] busy;
    xword_t      rs1_val;
    xword_t      rs2_val;

    logic        out_valid_d, out_valid_q;
    xword_t      out_instr_d, out_instr_q;
    xword_t      out_pc_d,    out_pc_q;
    xword_t      out_rs1_d,   out_rs1_q;
    xword_t      out_rs2_d,   out_rs2_q;
    reg_idx_t    out_rd_d,    out_rd_q;
    logic        out_ill_d,   out_ill_q;

    assign cls = classify(in_instr[6:0]);
    assign rs1 = rs1_of(in_instr);
    assign rs2 = rs2_of(in_instr);
    assign rd  = rd_of(in_instr);

    assign rf_rd_addr0 = rs1;
    assign rf_rd_addr1 = rs2;

    // A flushed entry never completes a handshake, so it cannot set busy.
    assign out_fire = out_valid_q && out_ready && !flush;

    scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (out_fire && out_rd_q != '0),
        .set_addr (out_rd_q),
        .clr_en   (wb_ena),
        .clr_addr (wb_addr),
        .qa_addr  (rs1),
        .qa_pend  (pend1),
        .qb_addr  (rs2),
        .qb_pend  (pend2),
        .busy     (busy)
    );

    assign pend_rd = busy[rd] && !(wb_ena && wb_addr == rd);

    // Producer still sitting in the output register has not set busy yet.
    function automatic logic in_flight(input reg_idx_t idx);
        return out_valid_q && out_rd_q != '0 && out_rd_q == idx;
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (cls.use_rs1 && rs1 != '0 && (pend1 || in_flight(rs1)))
            hazard = 1'b1;
        if (cls.use_rs2 && rs2 != '0 && (pend2 || in_flight(rs2)))
            hazard = 1'b1;
        if (cls.use_rd && rd != '0 && (pend_rd || in_flight(rd)))
            hazard = 1'b1;
    end

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    function automatic xword_t pick(input logic used, input reg_idx_t idx,
                                    input xword_t rf_val);
        if (!used || idx == '0)            return '0;
        else if (wb_ena && wb_addr == idx) return wb_data;
        else                               return rf_val;
    endfunction

    assign rs1_val = pick(cls.use_rs1, rs1, rf_rd_data0);
    assign rs2_val = pick(cls.use_rs2, rs2, rf_rd_data1);

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;
        out_ill_d   = out_ill_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_pc_d    = in_pc;
            out_rs1_d   = rs1_val;
            out_rs2_d   = rs2_val;
            out_rd_d    = cls.use_rd ? rd : '0;
            out_ill_d   = cls.illegal;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rd_q    <= out_rd_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_rs1_val = out_rs1_q;
    assign out_rs2_val = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
// Checks reset, issue, RAW bypass, x0, backpressure/flush, illegal.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_rd_addr0;
    logic [4:0]  rf_rd_addr1;
    logic [31:0] rf_rd_data0;
    logic [31:0] rf_rd_data1;
    logic        wb_ena;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_illegal;

    logic [31:0] rf [32];
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] ADDI_X4 = 32'h00118213;
    localparam logic [31:0] ADD_X0  = 32'h00000033;
    localparam logic [31:0] ADD_X5  = 32'h002082B3;
    localparam logic [31:0] ADDI_X7 = 32'h00300393;
    localparam logic [31:0] ADDI_X5 = 32'h00900293;
    localparam logic [31:0] ILLEGAL = 32'hFFFFFFFF;

    always #5 clk = ~clk;

    assign rf_rd_data0 = rf[rf_rd_addr0];
    assign rf_rd_data1 = rf[rf_rd_addr1];

    operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rf_rd_addr0 (rf_rd_addr0),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_data0 (rf_rd_data0),
        .rf_rd_data1 (rf_rd_data1),
        .wb_ena      (wb_ena),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] busy_bits();
        return dut.u_sb.busy;
    endfunction

    task automatic retire(input logic [4:0] a, input logic [31:0] d);
        wb_ena  = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_ena  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0]  = 32'h0;
        rf[1]  = 32'd5;
        rf[2]  = 32'd7;
        rf[31] = 32'hDEAD_BEEF;
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_ena = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", busy_bits(), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);

        tick();
        in_valid = 1'b1; in_instr = ADD_X3; in_pc = 32'h100;
        #1 check("add_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_rs1", out_rs1_val, 32'd5);
        check("add_rs2", out_rs2_val, 32'd7);
        check("add_rd", {27'b0, out_rd}, 32'd3);
        check("add_pc", out_pc, 32'h100);
        tick();
        check("add_busy", busy_bits(), 32'h8);
        check("add_drain", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; in_instr = ADDI_X4; in_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #1 check("raw_stall", {31'b0, in_ready}, 32'd0);
            tick();
        end
        wb_ena = 1'b1; wb_addr = 5'd3; wb_data = 32'd12;
        #1 check("raw_bypass_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb_ena = 1'b0; in_valid = 1'b0;
        check("raw_rs1", out_rs1_val, 32'd12);
        check("raw_rs2_unused", out_rs2_val, 32'd0);
        check("raw_rd", {27'b0, out_rd}, 32'd4);
        check("raw_busy_clr", busy_bits(), 32'd0);
        tick();
        check("raw_busy_x4", busy_bits(), 32'h10);
        retire(5'd4, 32'd0);

        in_valid = 1'b1; in_instr = ADD_X0; in_pc = 32'h108;
        wb_ena = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1 check("x0_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; wb_ena = 1'b0;
        check("x0_rs1", out_rs1_val, 32'd0);
        check("x0_rs2", out_rs2_val, 32'd0);
        check("x0_rd", {27'b0, out_rd}, 32'd0);
        tick();
        check("x0_busy", busy_bits(), 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = ADD_X5; in_pc = 32'h200;
        tick();
        in_instr = ADDI_X7; in_pc = 32'h204;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_pc", out_pc, 32'h200);
            check("bp_rs1", out_rs1_val, 32'd5);
            check("bp_rd", {27'b0, out_rd}, 32'd5);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        #1 check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; out_ready = 1'b1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_busy", busy_bits(), 32'd0);
        in_valid = 1'b1; in_instr = ADDI_X5; in_pc = 32'h208;
        #1 check("waw_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("waw_valid", {31'b0, out_valid}, 32'd1);
        check("waw_rd", {27'b0, out_rd}, 32'd5);
        check("waw_rs1", out_rs1_val, 32'd0);
        tick();
        check("waw_busy", busy_bits(), 32'h20);
        retire(5'd5, 32'd9);

        in_valid = 1'b1; in_instr = ILLEGAL; in_pc = 32'h300;
        #1 check("ill_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("ill_flag", {31'b0, out_illegal}, 32'd1);
        check("ill_rd", {27'b0, out_rd}, 32'd0);
        check("ill_rs1", out_rs1_val, 32'd0);
        check("ill_rs2", out_rs2_val, 32'd0);
        tick();
        check("ill_busy", busy_bits(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
